// File: rtl/ctrl_pkg.sv
// Shared control definitions: funct3 load/store encodings, LSU FSM states,
// access-size decode helpers.
package ctrl_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  // Undefined encodings (011, 110, 111) fall through to word size
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    lsu_size_e sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic f3_unsigned(input logic [2:0] f3);
    return (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational LSU lane logic: store byte enables and replication,
// misalignment detection / forced alignment, load lane select and extension.
// LSU_MISALIGN_CHECK_EN: flag misaligned halfword/word accesses; when
// undefined, sub-word offsets are forced to natural alignment instead.
module lsu_align
  import ctrl_pkg::*;
(
  input  logic            st_we_i,
  input  logic [2:0]      st_op_i,
  input  logic [1:0]      st_off_i,
  input  logic [XLEN-1:0] st_data_i,
  output logic [BE_W-1:0] be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            misalign_o,
  output logic [1:0]      eff_off_o,
  input  logic [2:0]      ld_op_i,
  input  logic [1:0]      ld_off_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] ld_data_o
);

  lsu_size_e   w_st_size;
  lsu_size_e   w_ld_size;
  logic [1:0]  w_off;
  logic [7:0]  w_b;
  logic [15:0] w_h;
  logic        w_sext;

  assign w_st_size = f3_size(st_op_i);

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_off      = st_off_i;
  assign misalign_o = ((w_st_size == SZ_H) && st_off_i[0]) ||
                      ((w_st_size == SZ_W) && (st_off_i != 2'b00));
`else
  // Drop the offset bits that would break natural alignment
  always_comb begin
    w_off = st_off_i;
    case (w_st_size)
      SZ_H:    w_off = {st_off_i[1], 1'b0};
      SZ_W:    w_off = 2'b00;
      default: w_off = st_off_i;
    endcase
  end
  assign misalign_o = 1'b0;
`endif

  assign eff_off_o = w_off;

  // Store byte enables and lane replication; loads enable the full word
  always_comb begin
    be_o    = {BE_W{1'b1}};
    wdata_o = st_data_i;
    if (st_we_i) begin
      case (w_st_size)
        SZ_B: begin
          be_o    = BE_W'(4'b0001) << w_off;
          wdata_o = {(BE_W){st_data_i[7:0]}};
        end
        SZ_H: begin
          be_o    = BE_W'(4'b0011) << w_off;
          wdata_o = {(BE_W/2){st_data_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign w_ld_size = f3_size(ld_op_i);
  assign w_b       = 8'(rdata_i >> {ld_off_i, 3'b000});
  assign w_h       = 16'(rdata_i >> {ld_off_i[1], 4'b0000});
  assign w_sext    = ~f3_unsigned(ld_op_i);

  // Load lane select with sign/zero extension
  always_comb begin
    ld_data_o = rdata_i;
    case (w_ld_size)
      SZ_B:    ld_data_o = {{(XLEN-8){w_sext & w_b[7]}}, w_b};
      SZ_H:    ld_data_o = {{(XLEN-16){w_sext & w_h[15]}}, w_h};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding request from execute, issued to a
// req/gnt/rvalid data memory port, single-cycle response pulse.
// LSU_MISALIGN_CHECK_EN: misaligned accesses answer with misalign_o and no
// memory access; otherwise they are forced to natural alignment.
module lsu
  import ctrl_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            mem_wren_i,
  input  logic [2:0]      loadsave_op_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] st_data_i,
  output logic            rsp_valid_o,
  output logic [XLEN-1:0] ld_data_o,
  output logic            misalign_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [BE_W-1:0] dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i
);

  lsu_state_e      r_state;
  lsu_state_e      w_state_nxt;
  logic            r_we;
  logic [2:0]      r_op;
  logic [1:0]      r_off;
  logic            r_misalign;
  logic [XLEN-1:0] r_dmem_addr;
  logic [BE_W-1:0] r_dmem_be;
  logic [XLEN-1:0] r_dmem_wdata;
  logic [XLEN-1:0] r_ld_data;

  logic            w_accept;
  logic [BE_W-1:0] w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_ld_data;
  logic            w_misalign;
  logic [1:0]      w_eff_off;

  assign w_accept = req_valid_i && (r_state == ST_IDLE);

  lsu_align u_align (
    .st_we_i    (mem_wren_i),
    .st_op_i    (loadsave_op_i),
    .st_off_i   (addr_i[1:0]),
    .st_data_i  (st_data_i),
    .be_o       (w_be),
    .wdata_o    (w_wdata),
    .misalign_o (w_misalign),
    .eff_off_o  (w_eff_off),
    .ld_op_i    (r_op),
    .ld_off_i   (r_off),
    .rdata_i    (dmem_rdata_i),
    .ld_data_o  (w_ld_data)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state: grant only matters in REQ, rvalid only in WAIT
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_misalign ? ST_RESP : ST_REQ;
      ST_REQ:  if (dmem_gnt_i) w_state_nxt = r_we ? ST_RESP : ST_WAIT;
      ST_WAIT: if (dmem_rvalid_i) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    req_ready_o = 1'b0;
    dmem_req_o  = 1'b0;
    rsp_valid_o = 1'b0;
    misalign_o  = 1'b0;
    case (r_state)
      ST_IDLE: req_ready_o = 1'b1;
      ST_REQ:  dmem_req_o  = 1'b1;
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        misalign_o  = r_misalign;
      end
      default: ;
    endcase
  end

  // Request payload capture and load-data register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we         <= 1'b0;
      r_op         <= 3'b000;
      r_off        <= 2'b00;
      r_misalign   <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_be    <= '0;
      r_dmem_wdata <= '0;
      r_ld_data    <= '0;
    end else begin
      if (w_accept) begin
        r_we         <= mem_wren_i;
        r_op         <= loadsave_op_i;
        r_off        <= w_eff_off;
        r_misalign   <= w_misalign;
        r_dmem_addr  <= {addr_i[XLEN-1:2], 2'b00};
        r_dmem_be    <= w_be;
        r_dmem_wdata <= mem_wren_i ? w_wdata : '0;
      end
      // ld_data only changes when a response is about to be presented
      if (w_accept && w_misalign)
        r_ld_data <= '0;
      else if ((r_state == ST_REQ) && dmem_gnt_i && r_we)
        r_ld_data <= '0;
      else if ((r_state == ST_WAIT) && dmem_rvalid_i)
        r_ld_data <= w_ld_data;
    end
  end

  assign dmem_we_o    = r_we;
  assign dmem_addr_o  = r_dmem_addr;
  assign dmem_be_o    = r_dmem_be;
  assign dmem_wdata_o = r_dmem_wdata;
  assign ld_data_o    = r_ld_data;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: vector table of single transactions with a
// behavioural memory responder, plus hand sequences for reset and idle noise.
module tb_lsu;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        mem_wren_i;
  logic [2:0]  loadsave_op_i;
  logic [31:0] addr_i;
  logic [31:0] st_data_i;
  logic        rsp_valid_o;
  logic [31:0] ld_data_o;
  logic        misalign_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  lsu dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .mem_wren_i    (mem_wren_i),
    .loadsave_op_i (loadsave_op_i),
    .addr_i        (addr_i),
    .st_data_i     (st_data_i),
    .rsp_valid_o   (rsp_valid_o),
    .ld_data_o     (ld_data_o),
    .misalign_o    (misalign_o),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_be_o     (dmem_be_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i)
  );

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ld;
    logic        mis;
    int          lat;   // cycle of rsp_valid_o, accept cycle counted as 1
    int          gd;    // extra cycles before grant
    int          rd;    // extra cycles after grant before rvalid
    logic [31:0] daddr;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic we, input logic [2:0] op,
                              input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [31:0] rdata, input logic [3:0] be,
                              input logic [31:0] wdata, input logic [31:0] ld,
                              input logic mis, input int lat, input int gd,
                              input int rd, input logic [31:0] daddr);
    vec_t v;
    v.we = we; v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
    v.be = be; v.wdata = wdata; v.ld = ld; v.mis = mis; v.lat = lat;
    v.gd = gd; v.rd = rd; v.daddr = daddr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One transaction with a memory that grants after v.gd cycles and
  // returns read data v.rd cycles after the grant cycle.
  task automatic run_txn(input vec_t v, input int idx);
    int  n, rsp_n, req_cyc, wait_cnt, nrsp;
    bit  granted, done, ready_bad, dmem_bad;
    req_valid_i   = 1'b1;
    mem_wren_i    = v.we;
    loadsave_op_i = v.op;
    addr_i        = v.addr;
    st_data_i     = v.sdata;
    chk($sformatf("v%0d_ready_idle", idx), 32'(req_ready_o), 32'd1);
    @(posedge clk_i); #1;
    req_valid_i   = 1'b0;
    mem_wren_i    = ~v.we;
    loadsave_op_i = 3'b001;
    addr_i        = 32'hFFFF_FFFF;
    st_data_i     = 32'h0;
    n = 1; rsp_n = 0; req_cyc = 0; wait_cnt = 0; nrsp = 0;
    granted = 0; done = 0; ready_bad = 0; dmem_bad = 0;
    while (!done && n <= 40) begin
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i  = 32'hA5A5_5A5A;
      if (dmem_req_o) begin
        req_cyc++;
        if (req_cyc == 1) begin
          chk($sformatf("v%0d_addr", idx), dmem_addr_o, v.daddr);
          chk($sformatf("v%0d_be", idx), 32'(dmem_be_o), 32'(v.be));
          chk($sformatf("v%0d_we", idx), 32'(dmem_we_o), 32'(v.we));
          if (v.we) chk($sformatf("v%0d_wdata", idx), dmem_wdata_o, v.wdata);
        end else if (dmem_addr_o !== v.daddr || dmem_be_o !== v.be ||
                     dmem_we_o !== v.we || (v.we && dmem_wdata_o !== v.wdata)) begin
          dmem_bad = 1;
        end
        if (req_cyc > v.gd) begin
          dmem_gnt_i = 1'b1;
          granted    = 1;
        end
      end else if (granted) begin
        if (wait_cnt == v.rd) begin
          dmem_rvalid_i = 1'b1;
          dmem_rdata_i  = v.rdata;
        end
        wait_cnt++;
      end
      if (rsp_valid_o) begin
        nrsp++;
        if (nrsp == 1) begin
          rsp_n = n;
          chk($sformatf("v%0d_latency", idx), 32'(n + 1), 32'(v.lat));
          chk($sformatf("v%0d_ld_data", idx), ld_data_o, v.ld);
          chk($sformatf("v%0d_misalign", idx), 32'(misalign_o), 32'(v.mis));
        end
      end
      if (nrsp > 0 && n == rsp_n + 1) begin
        chk($sformatf("v%0d_ready_back", idx), 32'(req_ready_o), 32'd1);
        chk($sformatf("v%0d_ld_hold", idx), ld_data_o, v.ld);
        done = 1;
      end else if (req_ready_o) begin
        ready_bad = 1;
      end
      if (!done) begin
        @(posedge clk_i); #1;
        n++;
      end
    end
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    chk($sformatf("v%0d_completed", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d_rsp_pulses", idx), 32'(nrsp), 32'd1);
    chk($sformatf("v%0d_req_cycles", idx), 32'(req_cyc), v.mis ? 32'd0 : 32'(v.gd + 1));
    chk($sformatf("v%0d_ready_low_busy", idx), 32'(ready_bad), 32'd0);
    chk($sformatf("v%0d_dmem_stable", idx), 32'(dmem_bad), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},  32'(req_ready_o), 32'd1);
    chk({tag, "_rsp"},    32'(rsp_valid_o), 32'd0);
    chk({tag, "_mis"},    32'(misalign_o),  32'd0);
    chk({tag, "_ld"},     ld_data_o,        32'd0);
    chk({tag, "_dreq"},   32'(dmem_req_o),  32'd0);
    chk({tag, "_dwe"},    32'(dmem_we_o),   32'd0);
    chk({tag, "_daddr"},  dmem_addr_o,      32'd0);
    chk({tag, "_dbe"},    32'(dmem_be_o),   32'd0);
    chk({tag, "_dwdata"}, dmem_wdata_o,     32'd0);
  endtask

  initial begin
    bit rsp_seen;
    rst_ni = 1'b0; req_valid_i = 1'b0; mem_wren_i = 1'b0; loadsave_op_i = 3'b000;
    addr_i = '0; st_data_i = '0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;

    //                 we  op      addr          sdata         rdata         be       wdata         ld            mis lat gd rd daddr
    vecs[0]  = mk(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0,        4'b1000, 32'hABAB_ABAB, 32'h0,        0, 3, 0, 0, 32'h0000_1000);
    vecs[1]  = mk(1'b0, 3'b000, 32'h0000_2002, 32'h0,        32'h12F4_5678, 4'b1111, 32'h0,        32'hFFFF_FFF4, 0, 4, 0, 0, 32'h0000_2000);
    vecs[2]  = mk(1'b0, 3'b100, 32'h0000_2002, 32'h0,        32'h12F4_5678, 4'b1111, 32'h0,        32'h0000_00F4, 0, 4, 0, 0, 32'h0000_2000);
    vecs[3]  = mk(1'b0, 3'b001, 32'h0000_2002, 32'h0,        32'h8001_5678, 4'b1111, 32'h0,        32'hFFFF_8001, 0, 4, 0, 0, 32'h0000_2000);
    vecs[4]  = mk(1'b0, 3'b101, 32'h0000_2002, 32'h0,        32'h8001_5678, 4'b1111, 32'h0,        32'h0000_8001, 0, 4, 0, 0, 32'h0000_2000);
    vecs[5]  = mk(1'b1, 3'b001, 32'h0000_4002, 32'h1234_ABCD, 32'h0,        4'b1100, 32'hABCD_ABCD, 32'h0,        0, 3, 0, 0, 32'h0000_4000);
    vecs[6]  = mk(1'b1, 3'b010, 32'h0000_4004, 32'hCAFE_F00D, 32'h0,        4'b1111, 32'hCAFE_F00D, 32'h0,        0, 3, 0, 0, 32'h0000_4004);
    vecs[7]  = mk(1'b0, 3'b011, 32'h0000_5008, 32'h0,        32'h0102_0304, 4'b1111, 32'h0,        32'h0102_0304, 0, 4, 0, 0, 32'h0000_5008);
    vecs[8]  = mk(1'b1, 3'b111, 32'h0000_500C, 32'h1122_3344, 32'h0,        4'b1111, 32'h1122_3344, 32'h0,        0, 3, 0, 0, 32'h0000_500C);
    vecs[9]  = mk(1'b0, 3'b000, 32'h0000_6001, 32'h0,        32'h0000_7F00, 4'b1111, 32'h0,        32'h0000_007F, 0, 4, 0, 0, 32'h0000_6000);
    vecs[10] = mk(1'b1, 3'b000, 32'h0000_7000, 32'hFFFF_FF5A, 32'h0,        4'b0001, 32'h5A5A_5A5A, 32'h0,        0, 3, 0, 0, 32'h0000_7000);
    vecs[11] = mk(1'b1, 3'b001, 32'h0000_7002, 32'h0000_BEEF, 32'h0,        4'b1100, 32'hBEEF_BEEF, 32'h0,        0, 5, 2, 0, 32'h0000_7000);
`ifdef LSU_MISALIGN_CHECK_EN
    vecs[12] = mk(1'b0, 3'b001, 32'h0000_2001, 32'h0,        32'h12F4_5678, 4'b1111, 32'h0,        32'h0,        1, 2, 0, 0, 32'h0000_2000);
    vecs[13] = mk(1'b1, 3'b010, 32'h0000_8002, 32'h0000_0055, 32'h0,        4'b1111, 32'h0000_0055, 32'h0,        1, 2, 0, 0, 32'h0000_8000);
    vecs[14] = mk(1'b0, 3'b001, 32'h0000_2003, 32'h0,        32'h12F4_5678, 4'b1111, 32'h0,        32'h0,        1, 2, 0, 0, 32'h0000_2000);
    vecs[15] = mk(1'b1, 3'b001, 32'h0000_8003, 32'h0000_A55A, 32'h0,        4'b1100, 32'hA55A_A55A, 32'h0,        1, 2, 0, 0, 32'h0000_8000);
`else
    vecs[12] = mk(1'b0, 3'b001, 32'h0000_2001, 32'h0,        32'h12F4_5678, 4'b1111, 32'h0,        32'h0000_5678, 0, 4, 0, 0, 32'h0000_2000);
    vecs[13] = mk(1'b1, 3'b010, 32'h0000_8002, 32'h0000_0055, 32'h0,        4'b1111, 32'h0000_0055, 32'h0,        0, 3, 0, 0, 32'h0000_8000);
    vecs[14] = mk(1'b0, 3'b001, 32'h0000_2003, 32'h0,        32'h12F4_5678, 4'b1111, 32'h0,        32'h0000_12F4, 0, 4, 0, 0, 32'h0000_2000);
    vecs[15] = mk(1'b1, 3'b001, 32'h0000_8003, 32'h0000_A55A, 32'h0,        4'b1100, 32'hA55A_A55A, 32'h0,        0, 3, 0, 0, 32'h0000_8000);
`endif
    vecs[16] = mk(1'b0, 3'b010, 32'h0000_3000, 32'h0,        32'hDEAD_BEEF, 4'b1111, 32'h0,        32'hDEAD_BEEF, 0, 9, 3, 2, 32'h0000_3000);

    // Reset values while held in reset
    repeat (3) @(posedge clk_i);
    #1;
    chk_reset_outputs("rst0");
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Grant/rvalid noise in IDLE must be ignored
    dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h7777_7777;
    rsp_seen = 0;
    repeat (2) begin
      @(posedge clk_i); #1;
      if (rsp_valid_o || dmem_req_o || !req_ready_o) rsp_seen = 1;
    end
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    chk("idle_noise_no_activity", 32'(rsp_seen), 32'd0);
    chk("idle_noise_ld", ld_data_o, 32'd0);

    for (int i = 0; i < NV; i++) run_txn(vecs[i], i);

    // Reset while a load waits for rvalid; late rvalid must be dropped
    req_valid_i = 1'b1; mem_wren_i = 1'b0; loadsave_op_i = 3'b010;
    addr_i = 32'h0000_9000; st_data_i = '0;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    chk("rstw_in_req", 32'(dmem_req_o), 32'd1);
    dmem_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    dmem_gnt_i = 1'b0;
    chk("rstw_in_wait", 32'({dmem_req_o, req_ready_o, rsp_valid_o}), 32'd0);
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs("rstw");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1357_9BDF;
    rsp_seen = 0;
    repeat (3) begin
      @(posedge clk_i); #1;
      dmem_rvalid_i = 1'b0;
      if (rsp_valid_o) rsp_seen = 1;
    end
    chk("rstw_no_rsp", 32'(rsp_seen), 32'd0);
    chk_reset_outputs("rstw_after");

    run_txn(vecs[1], 100);
    run_txn(vecs[0], 101);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
